bias_add_pipe: RTL and testbench

Multi-lane fixed-point bias adder for the LSTM gate datapath. It sits between the matrix-vector MAC array and the activation units. It adds a per-neuron, per-lane bias from an on-chip bias store to each incoming sum, optionally saturating. The block is a 2-stage valid/ready pipeline, so it accepts one beat of LANES values per cycle under backpressure.

---
 rtl/lstm_fx_pkg.sv | 46 ++++
 rtl/bias_sat_lane.sv | 33 +++
 rtl/bias_add_pipe.sv | 111 +++++++++++
 tb/tb_bias_add_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_fx_pkg.sv
// Shared fixed-point helpers for the LSTM datapath: default widths, range limits and a
// saturating adder that works on sign-extended operands.
package lstm_fx_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned FRAC_W_DEF = 12;

   // Operands are sign-extended into this width, so any w up to FX_MAX_W-1 cannot overflow.
   localparam int unsigned FX_MAX_W = 32;

   typedef logic signed [FX_MAX_W-1:0] fx_wide_t;

   typedef struct packed {
      logic     sat;
      fx_wide_t val;
   } fx_sat_t;

   function automatic fx_wide_t fx_max(input int unsigned w);
      fx_wide_t one;
      one = fx_wide_t'(1);
      return (one <<< (w - 1)) - one;
   endfunction

   function automatic fx_wide_t fx_min(input int unsigned w);
      fx_wide_t one;
      one = fx_wide_t'(1);
      return -(one <<< (w - 1));
   endfunction

   function automatic fx_sat_t sat_add(input fx_wide_t a, input fx_wide_t b, input int unsigned w);
      fx_sat_t  r;
      fx_wide_t s;
      s     = a + b;
      r.sat = 1'b1;
      if (s > fx_max(w)) begin
         r.val = fx_max(w);
      end else if (s < fx_min(w)) begin
         r.val = fx_min(w);
      end else begin
         r.val = s;
         r.sat = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/bias_sat_lane.sv
// One lane of the bias adder: sign-extend data and bias, add, then saturate when
// BIAS_ADD_SAT_EN is defined or wrap to DATA_W bits otherwise.
module bias_sat_lane
   import lstm_fx_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned BIAS_W = 16
) (
   input  logic [DATA_W-1:0] data,
   input  logic [BIAS_W-1:0] bias,
   output logic [DATA_W-1:0] result,
   output logic              sat
);

   fx_wide_t data_ext;
   fx_wide_t bias_ext;
   fx_sat_t  r;
   logic     unused_hi;

   assign data_ext = fx_wide_t'($signed(data));
   assign bias_ext = fx_wide_t'($signed(bias));

`ifdef BIAS_ADD_SAT_EN
   assign r = sat_add(data_ext, bias_ext, DATA_W);
`else
   assign r = '{sat: 1'b0, val: data_ext + bias_ext};
`endif

   assign result    = r.val[DATA_W-1:0];
   assign sat       = r.sat;
   assign unused_hi = ^r.val[FX_MAX_W-1:DATA_W];

endmodule

// File: rtl/bias_add_pipe.sv
// Two-stage valid/ready bias adder with a per-neuron bias store; lane saturation is
// enabled by defining BIAS_ADD_SAT_EN.
module bias_add_pipe
   import lstm_fx_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned FRAC_W  = FRAC_W_DEF,
   parameter int unsigned BIAS_W  = 16,
   parameter int unsigned LANES   = 4,
   parameter int unsigned NEURONS = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [LANES*DATA_W-1:0]    in_data,
   input  logic                       in_last,
   input  logic                       bias_we,
   input  logic [$clog2(NEURONS)-1:0] bias_addr,
   input  logic [LANES*BIAS_W-1:0]    bias_wdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LANES*DATA_W-1:0]    out_data,
   output logic                       out_last,
   output logic [LANES-1:0]           out_sat
);

   localparam int unsigned AW = $clog2(NEURONS);
   localparam logic [AW-1:0] IdxMax = AW'(NEURONS - 1);

   if (BIAS_W > DATA_W || FRAC_W >= DATA_W || DATA_W >= FX_MAX_W) begin : g_param_err
      $error("bias_add_pipe: unsupported DATA_W/FRAC_W/BIAS_W combination");
   end

   logic                    adv;
   logic                    accept;
   logic [AW-1:0]           idx_q, idx_d;
   logic                    s1_valid_q;
   logic [LANES*DATA_W-1:0] s1_data_q;
   logic                    s1_last_q;
   logic [LANES*BIAS_W-1:0] s1_bias_q;
   logic [LANES*BIAS_W-1:0] bias_mem [NEURONS];
   logic [LANES*DATA_W-1:0] sum_data;
   logic [LANES-1:0]        sum_sat;

   // Whole pipeline moves together; in_ready never depends on in_valid.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign accept   = in_valid && adv;

   always_comb begin
      idx_d = idx_q;
      if (accept) begin
         idx_d = (in_last || idx_q == IdxMax) ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         idx_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_last_q  <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         out_sat    <= '0;
      end else begin
         idx_q <= idx_d;
         if (adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_data_q <= in_data;
               s1_last_q <= in_last;
            end
            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
               out_data <= sum_data;
               out_last <= s1_last_q;
               out_sat  <= sum_sat;
            end
         end
      end
   end

   // Bias store is never reset; nonblocking write/read gives read-first on collision.
   always_ff @(posedge clk) begin
      if (bias_we) begin
         bias_mem[bias_addr] <= bias_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_bias_q <= bias_mem[idx_q];
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      bias_sat_lane #(
         .DATA_W(DATA_W),
         .BIAS_W(BIAS_W)
      ) u_lane (
         .data  (s1_data_q[i*DATA_W +: DATA_W]),
         .bias  (s1_bias_q[i*BIAS_W +: BIAS_W]),
         .result(sum_data[i*DATA_W +: DATA_W]),
         .sat   (sum_sat[i])
      );
   end

endmodule

// File: tb/tb_bias_add_pipe.sv
// Directed scoreboard bench for bias_add_pipe (LANES=2, NEURONS=4); expected beats are
// computed from a bias-store model when accepted and compared when they leave the DUT.
module tb_bias_add_pipe;

   localparam int DW = 16;
   localparam int BW = 16;
   localparam int L  = 2;
   localparam int N  = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [L*DW-1:0] in_data;
   logic            in_last;
   logic            bias_we;
   logic [1:0]      bias_addr;
   logic [L*BW-1:0] bias_wdata;
   logic            out_valid;
   logic            out_ready;
   logic [L*DW-1:0] out_data;
   logic            out_last;
   logic [L-1:0]    out_sat;

   typedef struct packed {
      logic [L*DW-1:0] data;
      logic [L-1:0]    sat;
      logic            last;
   } beat_t;

   beat_t           sb[$];
   logic [L*BW-1:0] m_bias [N];
   int              m_idx = 0;
   int              checks = 0;
   int              errors = 0;
   logic            held_v = 1'b0;
   beat_t           held;

   always #5 clk = ~clk;

   bias_add_pipe #(
      .DATA_W (DW),
      .FRAC_W (12),
      .BIAS_W (BW),
      .LANES  (L),
      .NEURONS(N)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .bias_we   (bias_we),
      .bias_addr (bias_addr),
      .bias_wdata(bias_wdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_sat   (out_sat)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   function automatic beat_t exp_beat(input logic [L*DW-1:0] d, input logic [L*BW-1:0] b,
                                      input logic last);
      beat_t         e;
      int            s;
      logic [DW-1:0] dl;
      logic [BW-1:0] bl;
      for (int i = 0; i < L; i++) begin
         dl = d[i*DW +: DW];
         bl = b[i*BW +: BW];
         s  = int'($signed(dl)) + int'($signed(bl));
         e.sat[i] = 1'b0;
`ifdef BIAS_ADD_SAT_EN
         if (s > 32767) begin
            s = 32767;
            e.sat[i] = 1'b1;
         end else if (s < -32768) begin
            s = -32768;
            e.sat[i] = 1'b1;
         end
`endif
         e.data[i*DW +: DW] = s[DW-1:0];
      end
      e.last = last;
      return e;
   endfunction

   // Evaluate handshakes just after the inputs settle, then advance one clock.
   task automatic tick(output bit acc);
      beat_t e;
      beat_t o;
      #1;
      acc = 1'b0;
      if (!rst) begin
         sb.delete();
         m_idx  = 0;
         held_v = 1'b0;
      end else begin
         o = '{data: out_data, sat: out_sat, last: out_last};
         if (held_v) begin
            check("hold_valid", out_valid, 1);
            check("hold_beat", o, held);
         end
         held_v = out_valid && !out_ready;
         held   = o;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_out", out_valid, 0);
            end else begin
               e = sb.pop_front();
               check("out_data", o.data, e.data);
               check("out_sat", o.sat, e.sat);
               check("out_last", o.last, e.last);
            end
         end
         if (in_valid && in_ready) begin
            acc = 1'b1;
            sb.push_back(exp_beat(in_data, m_bias[m_idx], in_last));
            m_idx = (in_last || m_idx == N - 1) ? 0 : m_idx + 1;
         end
      end
      if (bias_we) m_bias[bias_addr] = bias_wdata;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_in(input logic v, input logic [L*DW-1:0] d, input logic l);
      in_valid = v;
      in_data  = d;
      in_last  = l;
   endtask

   task automatic wr_bias(input int a, input logic [L*BW-1:0] w);
      bit acc;
      bias_we    = 1'b1;
      bias_addr  = 2'(a);
      bias_wdata = w;
      tick(acc);
      bias_we    = 1'b0;
   endtask

   task automatic drain();
      bit acc;
      set_in(1'b0, '0, 1'b0);
      out_ready = 1'b1;
      for (int c = 0; c < 20 && sb.size() != 0; c++) tick(acc);
      check("drain_empty", sb.size(), 0);
   endtask

   logic [L*DW-1:0] bp_data [10];

   initial begin
      bit acc;
      int k;
      int cyc;

      rst        = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_last    = 1'b0;
      bias_we    = 1'b0;
      bias_addr  = '0;
      bias_wdata = '0;
      out_ready  = 1'b1;
      tick(acc);
      tick(acc);
      rst = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_data", out_data, 0);
      check("rst_out_sat", out_sat, 0);
      check("rst_out_last", out_last, 0);

      for (int a = 0; a < N; a++) begin
         wr_bias(a, {16'(16'h0100 * (a + 1)), 16'(16'h0010 * (a + 1))});
      end

      // Basic add with two-cycle latency.
      wr_bias(0, 32'hF000_1000);
      set_in(1'b1, 32'h0800_0800, 1'b1);
      tick(acc);
      check("basic_accept", acc, 1);
      set_in(1'b0, '0, 1'b0);
      check("lat1_valid", out_valid, 0);
      tick(acc);
      check("lat2_valid", out_valid, 1);
      check("basic_data", out_data, 32'hF800_1800);
      check("basic_sat", out_sat, 2'b00);
      tick(acc);

      // Saturation / wrap at both range ends.
      wr_bias(0, 32'hF000_7000);
      set_in(1'b1, 32'h8000_2000, 1'b1);
      tick(acc);
      set_in(1'b0, '0, 1'b0);
      tick(acc);
`ifdef BIAS_ADD_SAT_EN
      check("sat_data", out_data, 32'h8000_7FFF);
      check("sat_flags", out_sat, 2'b11);
`else
      check("wrap_data", out_data, 32'h7000_9000);
      check("wrap_flags", out_sat, 2'b00);
`endif
      tick(acc);

      // Index wrap and in_last: 0,1,2(last),0,1,2 then 3,0,1,2,3.
      for (int a = 0; a < N; a++) begin
         wr_bias(a, {16'(16'h0111 * (a + 1)), 16'(16'h0022 * (a + 1))});
      end
      for (int i = 0; i < 11; i++) begin
         set_in(1'b1, $urandom, i == 2);
         tick(acc);
      end
      check("idx_after_wrap", m_idx, 0);
      drain();

      // Backpressure: out_ready low for three cycles mid-stream.
      for (int i = 0; i < 10; i++) bp_data[i] = $urandom;
      k   = 0;
      cyc = 0;
      while (k < 10 && cyc < 40) begin
         out_ready = !(cyc >= 3 && cyc < 6);
         set_in(1'b1, bp_data[k], k == 9);
         #1;
         if (!out_ready) check("bp_in_ready", in_ready, 0);
         tick(acc);
         if (acc) k++;
         cyc++;
      end
      check("bp_all_sent", k, 10);
      drain();

      // Reset with both stages full.
      set_in(1'b1, $urandom, 1'b0);
      tick(acc);
      set_in(1'b1, $urandom, 1'b0);
      tick(acc);
      check("pre_rst_valid", out_valid, 1);
      set_in(1'b0, '0, 1'b0);
      rst = 1'b0;
      tick(acc);
      rst = 1'b1;
      #1;
      check("post_rst_valid", out_valid, 0);
      check("post_rst_ready", in_ready, 1);
      check("post_rst_data", out_data, 0);
      set_in(1'b1, 32'h0001_0001, 1'b0);
      tick(acc);
      set_in(1'b0, '0, 1'b0);
      tick(acc);
      check("post_rst_bias0", out_data, 32'h0112_0023);

      // Read/write collision at index 1.
      set_in(1'b1, $urandom, 1'b0);
      bias_we    = 1'b1;
      bias_addr  = 2'd1;
      bias_wdata = 32'h1234_4321;
      tick(acc);
      bias_we = 1'b0;
      set_in(1'b1, 32'h0000_0000, 1'b1);
      tick(acc);
      set_in(1'b1, 32'h0000_0000, 1'b0);
      tick(acc);
      set_in(1'b1, 32'h0000_0000, 1'b0);
      tick(acc);
      set_in(1'b0, '0, 1'b0);
      tick(acc);
      check("collide_new_bias", out_data, 32'h1234_4321);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
